serial_sum_node: RTL and testbench

SERIAL_SUM_NODE -- requirements
Module: serial_sum_node

---
 rtl/serial_sum_node_if.sv | 34 +++
 rtl/serial_sum_node.sv | 124 ++++++++++++
 tb/tb_serial_sum_node.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_sum_node_if.sv
// Purpose: handshake bundle for the bit-serial sum node.
// Ports: per-channel IN_REQ/IN_ACK/IN_DATA; result side OUT_REQ/OUT_ACK/OUT_DATA/OUT_OVF.
// slave = node side (drives IN_REQ and the OUT_* outputs); master = producers and consumer.
interface serial_sum_node_if #(
  parameter int NUM_IN = 3
);
  logic [NUM_IN-1:0] IN_REQ;
  logic [NUM_IN-1:0] IN_ACK;
  logic [NUM_IN-1:0] IN_DATA;
  logic              OUT_REQ;
  logic              OUT_ACK;
  logic              OUT_DATA;
  logic              OUT_OVF;

  modport slave (
    output IN_REQ,
    input  IN_ACK,
    input  IN_DATA,
    input  OUT_REQ,
    output OUT_ACK,
    output OUT_DATA,
    output OUT_OVF
  );

  modport master (
    input  IN_REQ,
    output IN_ACK,
    output IN_DATA,
    output OUT_REQ,
    input  OUT_ACK,
    input  OUT_DATA,
    input  OUT_OVF
  );
endinterface

// File: rtl/serial_sum_node.sv
// Purpose: sums NUM_IN bit-serial words (LSB first) and returns the sum bit-serially.
// Latency: last input bit at edge t -> result loaded at t+1 -> OUT_ACK in cycle after t+2.
// Backpressure: channels stay FULL (IN_REQ=0) while the result buffer is occupied.
// Ports: CLK, RSTB (async active-low), bus (serial_sum_node_if.slave).
module serial_sum_node #(
  parameter int NUM_IN = 3,
  parameter int WIDTH  = 8,
  parameter bit SAT    = 1'b0
) (
  input  logic              CLK,
  input  logic              RSTB,
  serial_sum_node_if.slave  bus
);
  localparam int SW = WIDTH + $clog2(NUM_IN);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {CH_IDLE, CH_SHIFT, CH_FULL} ch_state_t;
  typedef enum logic [1:0] {BUF_EMPTY, BUF_HOLD, BUF_ACK, BUF_SEND} buf_state_t;

  ch_state_t        ch_q      [NUM_IN];
  ch_state_t        ch_d      [NUM_IN];
  logic [CW-1:0]    bit_cnt_q [NUM_IN];
  logic [WIDTH-1:0] sreg_q    [NUM_IN];

  buf_state_t       buf_q;
  buf_state_t       buf_d;
  logic [WIDTH-1:0] res_q;
  logic             ovf_q;
  logic [CW-1:0]    out_cnt_q;

  logic             all_full;
  logic             load;
  logic [SW-1:0]    sum;
  logic             sum_ovf;
  logic [WIDTH-1:0] sum_res;
  logic [NUM_IN-1:0] in_req_c;

  // Full-width sum of all channel words; only meaningful when every channel is FULL.
  always_comb begin
    all_full = 1'b1;
    sum      = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      all_full = all_full & (ch_q[k] == CH_FULL);
      sum      = sum + SW'(sreg_q[k]);
    end
  end

  assign load    = all_full && (buf_q == BUF_EMPTY);
  assign sum_ovf = |sum[SW-1:WIDTH];
  assign sum_res = (SAT && sum_ovf) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

  // Channel FSMs: IN_ACK is only looked at in IDLE.
  always_comb begin
    for (int k = 0; k < NUM_IN; k++) begin
      ch_d[k]     = ch_q[k];
      in_req_c[k] = (ch_q[k] == CH_IDLE);
      unique case (ch_q[k])
        CH_IDLE:  if (bus.IN_ACK[k]) ch_d[k] = CH_SHIFT;
        CH_SHIFT: if (bit_cnt_q[k] == CW'(WIDTH - 1)) ch_d[k] = CH_FULL;
        CH_FULL:  if (load) ch_d[k] = CH_IDLE;
        default:  ch_d[k] = CH_IDLE;
      endcase
    end
  end

  assign bus.IN_REQ = in_req_c;

  // Words enter at the MSB and shift right, so after WIDTH bits bit 0 sits at the LSB.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      for (int k = 0; k < NUM_IN; k++) begin
        ch_q[k]      <= CH_IDLE;
        bit_cnt_q[k] <= '0;
        sreg_q[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        ch_q[k] <= ch_d[k];
        if ((ch_q[k] == CH_IDLE && bus.IN_ACK[k]) || ch_q[k] == CH_SHIFT) begin
          sreg_q[k]    <= {bus.IN_DATA[k], sreg_q[k][WIDTH-1:1]};
          bit_cnt_q[k] <= (ch_q[k] == CH_IDLE) ? CW'(1) : bit_cnt_q[k] + CW'(1);
        end
      end
    end
  end

  // Result buffer: OUT_REQ is a level and only matters in HOLD.
  always_comb begin
    buf_d = buf_q;
    unique case (buf_q)
      BUF_EMPTY: if (load) buf_d = BUF_HOLD;
      BUF_HOLD:  if (bus.OUT_REQ) buf_d = BUF_ACK;
      BUF_ACK:   buf_d = BUF_SEND;
      BUF_SEND:  if (out_cnt_q == CW'(WIDTH - 1)) buf_d = BUF_EMPTY;
      default:   buf_d = BUF_EMPTY;
    endcase
  end

  // Outputs decode straight from state so reset clears them without waiting for a clock.
  assign bus.OUT_ACK  = (buf_q == BUF_ACK);
  assign bus.OUT_OVF  = (buf_q == BUF_ACK) & ovf_q;
  assign bus.OUT_DATA = (buf_q == BUF_SEND) & res_q[0];

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      buf_q     <= BUF_EMPTY;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      out_cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      if (load) begin
        res_q <= sum_res;
        ovf_q <= sum_ovf;
      end
      if (buf_q == BUF_ACK) begin
        out_cnt_q <= '0;
      end else if (buf_q == BUF_SEND) begin
        res_q     <= res_q >> 1;
        out_cnt_q <= out_cnt_q + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_serial_sum_node.sv
// Purpose: directed bench for serial_sum_node, SAT=0 and SAT=1 instances fed in parallel.
// Ports: none; drives both instances through serial_sum_node_if and collects serial results.
// Results are deserialised by a monitor into queues of {ovf, result}.
module tb_serial_sum_node;
  logic       CLK = 1'b0;
  logic       RSTB = 1'b1;
  logic [2:0] in_ack = '0;
  logic [2:0] ack_inj = '0;
  logic [2:0] in_data = '0;
  logic       out_req = 1'b0;

  int tests = 0;
  int fails = 0;
  int exp_acks = 0;

  serial_sum_node_if #(.NUM_IN(3)) bus0 ();
  serial_sum_node_if #(.NUM_IN(3)) bus1 ();

  assign bus0.IN_ACK  = in_ack | ack_inj;
  assign bus0.IN_DATA = in_data;
  assign bus0.OUT_REQ = out_req;
  assign bus1.IN_ACK  = in_ack | ack_inj;
  assign bus1.IN_DATA = in_data;
  assign bus1.OUT_REQ = out_req;

  serial_sum_node #(.NUM_IN(3), .WIDTH(8), .SAT(1'b0)) dut0 (.CLK(CLK), .RSTB(RSTB), .bus(bus0));
  serial_sum_node #(.NUM_IN(3), .WIDTH(8), .SAT(1'b1)) dut1 (.CLK(CLK), .RSTB(RSTB), .bus(bus1));

  always #5 CLK = ~CLK;

  // Monitor: deserialise each result after its OUT_ACK pulse.
  logic [1:0] mon_ack, mon_dat, mon_ovf;
  assign mon_ack = {bus1.OUT_ACK, bus0.OUT_ACK};
  assign mon_dat = {bus1.OUT_DATA, bus0.OUT_DATA};
  assign mon_ovf = {bus1.OUT_OVF, bus0.OUT_OVF};

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int         m_cnt[2]   = '{0, 0};
  logic [7:0] m_res[2];
  logic       m_ovf[2];
  int         ack_cnt[2] = '{0, 0};
  int         stray[2]   = '{0, 0};

  always @(negedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      if (!RSTB) begin
        m_cnt[d] = 0;
      end else if (m_cnt[d] > 0) begin
        m_res[d] = {mon_dat[d], m_res[d][7:1]};
        m_cnt[d] = m_cnt[d] - 1;
        if (mon_ack[d] || mon_ovf[d]) stray[d]++;
        if (m_cnt[d] == 0) begin
          if (d == 0) q0.push_back({m_ovf[d], m_res[d]});
          else        q1.push_back({m_ovf[d], m_res[d]});
        end
      end else if (mon_ack[d]) begin
        m_cnt[d] = 8;
        m_ovf[d] = mon_ovf[d];
        ack_cnt[d]++;
        if (mon_dat[d]) stray[d]++;
      end else if (mon_dat[d] || mon_ovf[d]) begin
        stray[d]++;
      end
    end
  end

  typedef struct {
    logic [7:0] w0, w1, w2;
    logic [7:0] r0;
    logic       o0;
    logic [7:0] r1;
    logic       o1;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive three serial words; channel k starts at cycle s_k. Returns at the negedge after the last bit.
  task automatic send(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                      input int s0, input int s1, input int s2);
    logic [7:0] w[3];
    int s[3];
    int last;
    int idx;
    w = '{w0, w1, w2};
    s = '{s0, s1, s2};
    last = s0;
    if (s1 > last) last = s1;
    if (s2 > last) last = s2;
    last = last + 8;
    for (int c = 0; c < last; c++) begin
      @(negedge CLK);
      for (int k = 0; k < 3; k++) begin
        idx = c - s[k];
        in_ack[k]  = (idx == 0);
        in_data[k] = (idx >= 0 && idx < 8) ? w[k][idx] : 1'b0;
      end
    end
    @(negedge CLK);
    in_ack  = '0;
    in_data = '0;
  endtask

  // With buffer empty and OUT_REQ high, OUT_ACK must appear exactly in the cycle after edge t+2.
  task automatic lat_check(input string nm);
    @(negedge CLK);
    check({nm, " ack_early"}, 32'(bus0.OUT_ACK), 32'd0);
    @(negedge CLK);
    check({nm, " ack_t2"}, 32'(bus0.OUT_ACK), 32'd1);
  endtask

  task automatic wait_res(input string nm, output logic [8:0] r0, output logic [8:0] r1);
    int n;
    n = 0;
    while ((q0.size() == 0 || q1.size() == 0) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (q0.size() == 0 || q1.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: no result within 300 cycles (q0=%0d q1=%0d)", nm, q0.size(), q1.size());
      r0 = '0;
      r1 = '0;
    end else begin
      r0 = q0.pop_front();
      r1 = q1.pop_front();
    end
  endtask

  task automatic expect_res(input string nm, input logic [7:0] e0, input logic eo0,
                            input logic [7:0] e1, input logic eo1);
    logic [8:0] r0, r1;
    wait_res(nm, r0, r1);
    exp_acks++;
    check({nm, " res_sat0"}, 32'(r0[7:0]), 32'(e0));
    check({nm, " ovf_sat0"}, 32'(r0[8]), 32'(eo0));
    check({nm, " res_sat1"}, 32'(r1[7:0]), 32'(e1));
    check({nm, " ovf_sat1"}, 32'(r1[8]), 32'(eo1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0;
    vt[0] = '{8'h10, 8'h20, 8'h30, 8'h60, 1'b0, 8'h60, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 8'h01, 8'h01, 1'b1, 8'hFF, 1'b1};
    vt[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFD, 1'b1, 8'hFF, 1'b1};
    vt[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[4] = '{8'h80, 8'h7F, 8'h00, 8'hFF, 1'b0, 8'hFF, 1'b0};
    vt[5] = '{8'h80, 8'h7F, 8'h01, 8'h00, 1'b1, 8'hFF, 1'b1};
    vt[6] = '{8'h12, 8'h34, 8'h56, 8'h9C, 1'b0, 8'h9C, 1'b0};

    // Reset state
    #2 RSTB = 1'b0;
    #1;
    check("rst in_req0", 32'(bus0.IN_REQ), 32'h7);
    check("rst in_req1", 32'(bus1.IN_REQ), 32'h7);
    check("rst out_ack", 32'(bus0.OUT_ACK), 32'd0);
    check("rst out_data", 32'(bus0.OUT_DATA), 32'd0);
    check("rst out_ovf", 32'(bus0.OUT_OVF), 32'd0);
    repeat (2) @(negedge CLK);
    #2 RSTB = 1'b1;

    // Table: aligned starts, OUT_REQ held high
    out_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(vt[i].w0, vt[i].w1, vt[i].w2, 0, 0, 0);
      lat_check($sformatf("vec%0d", i));
      expect_res($sformatf("vec%0d", i), vt[i].r0, vt[i].o0, vt[i].r1, vt[i].o1);
      repeat (2) @(negedge CLK);
    end

    // Staggered starts with stray IN_ACK on a FULL and a SHIFT channel
    fork
      send(8'h05, 8'h06, 8'h07, 0, 5, 20);
      begin
        repeat (12) @(negedge CLK);
        check("stagger in_req", 32'(bus0.IN_REQ), 32'h4);
        repeat (11) @(negedge CLK);
        ack_inj = 3'b101;
        @(negedge CLK);
        ack_inj = 3'b000;
      end
    join
    lat_check("stagger");
    expect_res("stagger", 8'h12, 1'b0, 8'h12, 1'b0);
    repeat (2) @(negedge CLK);

    // Two frames while OUT_REQ is low: second frame is back-pressured
    out_req = 1'b0;
    a0 = ack_cnt[0];
    send(8'h01, 8'h02, 8'h03, 0, 0, 0);
    send(8'h11, 8'h22, 8'h33, 0, 0, 0);
    repeat (20) @(negedge CLK);
    check("frames in_req", 32'(bus0.IN_REQ), 32'h0);
    check("frames held", 32'(ack_cnt[0] - a0), 32'd0);
    out_req = 1'b1;
    expect_res("frame1", 8'h06, 1'b0, 8'h06, 1'b0);
    expect_res("frame2", 8'h66, 1'b0, 8'h66, 1'b0);
    repeat (2) @(negedge CLK);

    // Reset after four bits of channel 0
    for (int b = 0; b < 4; b++) begin
      @(negedge CLK);
      in_ack  = (b == 0) ? 3'b001 : 3'b000;
      in_data = {2'b00, b[0]};
    end
    @(negedge CLK);
    in_ack  = '0;
    in_data = '0;
    check("midword in_req", 32'(bus0.IN_REQ), 32'h6);
    #2 RSTB = 1'b0;
    #1;
    check("midword rst in_req", 32'(bus0.IN_REQ), 32'h7);
    @(negedge CLK);
    #2 RSTB = 1'b1;
    a0 = ack_cnt[0];
    repeat (30) @(negedge CLK);
    check("midword no ack", 32'(ack_cnt[0] - a0), 32'd0);
    send(8'h01, 8'h02, 8'h03, 0, 0, 0);
    lat_check("after_rst");
    expect_res("after_rst", 8'h06, 1'b0, 8'h06, 1'b0);
    repeat (2) @(negedge CLK);

    // Reset in the middle of SEND discards the result
    send(8'h0F, 8'h0F, 8'h0F, 0, 0, 0);
    lat_check("midsend");
    exp_acks++;
    repeat (3) @(negedge CLK);
    check("midsend data bit2", 32'(bus0.OUT_DATA), 32'd1);
    #2 RSTB = 1'b0;
    #1;
    check("midsend rst data", 32'(bus0.OUT_DATA), 32'd0);
    check("midsend rst in_req", 32'(bus0.IN_REQ), 32'h7);
    @(negedge CLK);
    #2 RSTB = 1'b1;
    repeat (30) @(negedge CLK);
    check("midsend no result", 32'(q0.size() + q1.size()), 32'd0);

    // Totals
    check("ack count sat0", 32'(ack_cnt[0]), 32'(exp_acks));
    check("ack count sat1", 32'(ack_cnt[1]), 32'(exp_acks));
    check("stray sat0", 32'(stray[0]), 32'd0);
    check("stray sat1", 32'(stray[1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
